// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and helpers for the round-robin decode arbiter.
// Holds the FSM state encoding, default sizing constants and the
// priority-pointer wrap helper used when a grant is released.
package rr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int N_DEF       = 4;
   localparam int TIMEOUT_DEF = 255;

   // (idx + 1) mod 2**n, used to move the priority pointer past the
   // requester that was just served.
   function automatic logic [31:0] next_idx(input logic [31:0] idx,
                                            input int unsigned n);
      return (idx + 32'd1) & ((32'd1 << n) - 32'd1);
   endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Requester-side bundle for the round-robin decode arbiter.
// master: requester agents drive req/done and observe the grant.
// slave : the arbiter consumes req/done and drives the grant outputs.
interface rr_decode_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int N = N_DEF
) ();

   logic [2**N-1:0] req;          // level-held request vector
   logic            done;         // granted requester finished
   logic            gnt_valid;    // a grant is active
   logic [N-1:0]    gnt_idx;      // binary index of granted requester
   logic [2**N-1:0] gnt_onehot;   // decoded grant, zero when idle
   logic            err_timeout;  // one-cycle forced-release pulse

   modport master (
      output req,
      output done,
      input  gnt_valid,
      input  gnt_idx,
      input  gnt_onehot,
      input  err_timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt_valid,
      output gnt_idx,
      output gnt_onehot,
      output err_timeout
   );

endinterface

// File: rtl/rr_decode_arbiter_decoder.sv
// N-to-2**N one-hot decoder with enable.
// Ports: i_idx (binary index), i_en (qualifier), o_onehot (decoded lines).
// Purely combinational; output is all zero while i_en is low.
module onehot_decoder
   import rr_arb_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0]    i_idx,
   input  logic            i_en,
   output logic [2**N-1:0] o_onehot
);

   localparam int NR = 2**N;

   logic [NR-1:0] w_one;

   assign w_one    = NR'(1);
   assign o_onehot = i_en ? (w_one << i_idx) : '0;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one decoded strobe resource among 2**N requesters.
// Ports: clk, rst_n (sync, active-low); bus.slave carries req/done in and
// gnt_valid/gnt_idx/gnt_onehot/err_timeout out. Grant one cycle after request,
// held until done, request drop, or watchdog expiry; one IDLE cycle between grants.
module rr_decode_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rr_decode_arbiter_if.slave   bus
);

   localparam int            NR          = 2**N;
   localparam logic [TW-1:0] LP_CNT_LAST = TW'(TIMEOUT - 1);

   arb_state_t    r_state;
   logic [N-1:0]  r_ptr;
   logic [N-1:0]  r_gnt_idx;
   logic          r_gnt_valid;
   logic          r_err;
   logic [TW-1:0] r_cnt;

   logic [2*NR-1:0] w_req_dbl;
   logic [NR-1:0]   w_req_rot;
   logic [N-1:0]    w_off;
   logic [N-1:0]    w_pick;
   logic            w_any_req;
   logic            w_abandon;
   logic            w_wd_hit;

   // Rotate the request vector so bit 0 is the requester at the pointer,
   // find the lowest set bit, then rotate the result back by adding ptr.
   assign w_req_dbl = {bus.req, bus.req} >> r_ptr;
   assign w_req_rot = w_req_dbl[NR-1:0];
   assign w_any_req = |bus.req;

   always_comb begin
      w_off = '0;
      // Scanning downward leaves the lowest set position in w_off.
      for (int i = NR - 1; i >= 0; i--) begin
         if (w_req_rot[i]) begin
            w_off = N'(i);
         end
      end
   end

   assign w_pick    = r_ptr + w_off;   // N-bit add wraps modulo 2**N
   assign w_abandon = ~bus.req[r_gnt_idx];
   assign w_wd_hit  = (r_cnt == LP_CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_gnt_idx   <= '0;
         r_gnt_valid <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_gnt_idx   <= w_pick;
                  r_gnt_valid <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               // done and request-drop outrank the watchdog, so a done
               // landing on the final watchdog cycle never flags an error.
               if (bus.done || w_abandon || w_wd_hit) begin
                  r_gnt_valid <= 1'b0;
                  r_ptr       <= N'(next_idx(32'(r_gnt_idx), N));
                  r_state     <= IDLE;
                  r_err       <= ~bus.done & ~w_abandon;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   onehot_decoder #(
      .N (N)
   ) u_dec (
      .i_idx    (r_gnt_idx),
      .i_en     (r_gnt_valid),
      .o_onehot (bus.gnt_onehot)
   );

   assign bus.gnt_valid   = r_gnt_valid;
   assign bus.gnt_idx     = r_gnt_idx;
   assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter: each driven cycle pushes the
// expected post-edge outputs; a monitor pops and compares on every falling edge.
module tb_rr_decode_arbiter;

   localparam int N       = 4;
   localparam int NR      = 16;
   localparam int TIMEOUT = 4;

   typedef struct {
      bit          valid;
      int          idx;
      logic [15:0] onehot;
      bit          err;
   } exp_t;

   logic clk;
   logic rst_n;

   rr_decode_arbiter_if #(.N(N)) bus ();

   rr_decode_arbiter #(
      .N       (N),
      .TIMEOUT (TIMEOUT),
      .TW      (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   glog[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   bit m_busy = 0;
   int m_ptr  = 0;
   int m_idx  = 0;
   int m_cnt  = 0;
   bit m_err  = 0;

   task automatic m_release();
      m_busy = 0;
      m_ptr  = (m_idx + 1) % NR;
   endtask

   // Drive one cycle of inputs, predict the outputs after the next rising
   // edge, and advance to the following falling edge.
   task automatic cyc(input logic [15:0] r, input bit d, input bit rn);
      exp_t e;
      bus.req  = r;
      bus.done = d;
      rst_n    = rn;
      if (!rn) begin
         m_busy = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_err = 0;
      end else if (!m_busy) begin
         m_err = 0;
         if (r != 16'h0) begin
            for (int k = 0; k < NR; k++) begin
               int c;
               c = (m_ptr + k) % NR;
               if (r[c]) begin
                  m_idx = c;
                  break;
               end
            end
            m_busy = 1;
            m_cnt  = 0;
         end
      end else begin
         m_err = 0;
         if (d || !r[m_idx]) begin
            m_release();
         end else if (m_cnt == TIMEOUT - 1) begin
            m_release();
            m_err = 1;
         end else begin
            m_cnt++;
         end
      end
      e.valid  = m_busy;
      e.idx    = m_idx;
      e.onehot = m_busy ? (16'h0001 << m_idx) : 16'h0000;
      e.err    = m_err;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: compares every cycle's outputs against the oldest prediction.
   initial begin
      exp_t e;
      bit   prev_valid = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.err_timeout} !==
                {e.valid, 4'(e.idx), e.onehot, e.err}) begin
               n_fail++;
               $display("FAIL outputs @%0t: got valid=%0b idx=%0d onehot=%h err=%0b, want valid=%0b idx=%0d onehot=%h err=%0b",
                        $time, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.err_timeout,
                        e.valid, e.idx, e.onehot, e.err);
            end
            if (bus.gnt_valid === 1'b1 && !prev_valid) glog.push_back(int'(bus.gnt_idx));
            prev_valid = (bus.gnt_valid === 1'b1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bus.req  = '0;
      bus.done = 1'b0;
      rst_n    = 1'b0;

      // Reset held with all requests high
      for (int i = 0; i < 3; i++) cyc(16'hFFFF, 0, 0);
      glog.delete();

      // Round robin: 17 grants, done two cycles after each grant
      for (int g = 0; g < 17; g++) begin
         cyc(16'hFFFF, 0, 1);
         cyc(16'hFFFF, 0, 1);
         cyc(16'hFFFF, 1, 1);
      end
      n_checks++;
      if (glog.size() != 17) begin
         n_fail++;
         $display("FAIL rr_count: got %0d grants, want 17", glog.size());
      end else begin
         for (int g = 0; g < 17; g++) begin
            n_checks++;
            if (glog[g] != g % 16) begin
               n_fail++;
               $display("FAIL rr_order[%0d]: got idx %0d, want %0d", g, glog[g], g % 16);
            end
         end
      end

      // Wrap and skip: serve 13 so ptr=14, then 0x0021 gives 0 then 5
      cyc(16'h2000, 0, 1);
      cyc(16'h2000, 1, 1);
      cyc(16'h0021, 0, 1);
      cyc(16'h0021, 1, 1);
      cyc(16'h0021, 0, 1);
      cyc(16'h0021, 1, 1);
      cyc(16'h0000, 0, 1);

      // Watchdog expiry with done held low, then regrant of 8
      for (int i = 0; i < 12; i++) cyc(16'h0100, 0, 1);
      cyc(16'h0000, 0, 1);
      cyc(16'h0000, 0, 1);

      // done on the final watchdog cycle: no error
      cyc(16'h0100, 0, 1);
      for (int i = 0; i < 3; i++) cyc(16'h0100, 0, 1);
      cyc(16'h0100, 1, 1);
      cyc(16'h0000, 0, 1);

      // Abandon, then reset in the middle of a grant
      cyc(16'h0008, 0, 1);
      cyc(16'h0000, 0, 1);
      cyc(16'h0000, 0, 1);
      cyc(16'h0080, 0, 1);
      cyc(16'h0080, 0, 1);
      cyc(16'h0080, 0, 0);
      cyc(16'h0088, 0, 1);
      cyc(16'h0088, 1, 1);
      cyc(16'h0000, 0, 1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] r;
         r = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom & $urandom);
         cyc(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));
      end
      cyc(16'h0000, 0, 1);

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one decoded strobe resource among 2**N requesters.
- Each requester holds a line until it signals done, or until a watchdog expires.
- The grant index drives an N-to-2**N one-hot decoder; the one-hot output selects or toggles the granted flip-flop bank slice.
- Sits between the requester agents and the decoded flip-flop array.

Parameters:
- N, 4: select width; number of requesters = 2**N (16 by default).
- TIMEOUT, 255: maximum BUSY cycles before forced release; must be >= 1.
- TW, 8: watchdog counter width; must satisfy 2**TW > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  2**N  request vector, one bit per requester, level-held.
- done  in  1  granted requester finished; sampled only in BUSY.
- gnt_valid  out  1  a grant is active.
- gnt_idx  out  N  binary index of the granted requester.
- gnt_onehot  out  2**N  decoded grant: one-hot of gnt_idx when gnt_valid=1, else all zero.
- err_timeout  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk.
- Reset values:
  - state = IDLE
  - gnt_valid = 0, gnt_idx = 0, gnt_onehot = 0
  - err_timeout = 0
  - priority pointer ptr = 0
  - watchdog count = 0
- States: IDLE, BUSY (2-state FSM, registered).
- IDLE:
  - If req != 0, pick the first set bit scanning upward from ptr, wrapping modulo 2**N.
  - Register that index into gnt_idx, set gnt_valid = 1, clear count, go to BUSY.
  - If req == 0, stay in IDLE with outputs unchanged at zero/hold.
- BUSY: count increments each cycle. Release conditions, highest priority first:
  - (a) done = 1: normal release.
  - (b) req[gnt_idx] = 0: requester abandoned the grant; treated as a normal release, no error.
  - (c) count == TIMEOUT - 1: forced release; err_timeout = 1 in the next cycle.
- On any release:
  - gnt_valid = 0 next cycle.
  - ptr = gnt_idx + 1, wrapping from 2**N - 1 to 0.
  - Return to IDLE.
- Simultaneous done and timeout: done wins, no err_timeout.
- Latency:
  - req rising in IDLE at edge t gives gnt_valid = 1 after edge t+1.
  - done at edge t gives gnt_valid = 0 after edge t+1.
  - The next grant appears after edge t+2 at the earliest (one mandatory IDLE cycle between grants; no back-to-back grants).
- gnt_onehot: combinational decode of registered gnt_idx, ANDed with gnt_valid. Glitch-free relative to clk; no combinational path from req.
- Fairness: with all 16 requesters asserted, grants cycle 0, 1, …, 15, 0 … in order.
- gnt_idx holds its last value after release. Consumers must qualify it with gnt_valid.
- Reset mid-BUSY: grant drops on the reset edge, ptr returns to 0, and any pending err_timeout is suppressed.
- Requests arriving during BUSY are not evaluated until IDLE. A requester whose bit drops before being granted is simply skipped.

Decomposition:
- Shared package rr_arb_pkg:
  - state enum (IDLE = 1'b0, BUSY = 1'b1)
  - default N = 4 and TIMEOUT = 255 constants
  - a next-index wrap function, (idx + 1) mod 2**N
- One sub-module, onehot_decoder:
  - parameter N, input idx[N-1:0], input en, output [2**N-1:0].
  - Pure combinational; instantiated once for gnt_onehot.
- Priority scan (rotate, find first set, rotate back) stays inline in the arbiter.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with req = 16'hFFFF → gnt_valid = 0, gnt_onehot = 0, err_timeout = 0. After release, first grant gnt_idx = 0, gnt_onehot = 16'h0001.
- Round robin: req = 16'hFFFF, pulse done 2 cycles after each grant → gnt_idx sequence 0, 1, 2, …, 15, 0. Each gnt_onehot = 1 << gnt_idx, with one gnt_valid = 0 cycle between grants.
- Wrap and skip: ptr = 14 (grant 13 then release), req = 16'h0021 → next gnt_idx = 0 (onehot 16'h0001). After its release, gnt_idx = 5 (16'h0020).
- Timeout: TIMEOUT = 4, req = 16'h0100, done held 0 → gnt_valid high exactly 4 cycles. err_timeout pulses once. The next grant is again idx 8 after one IDLE cycle.
- Done vs timeout collision: TIMEOUT = 4, assert done on the 4th BUSY cycle → release with err_timeout = 0.
- Abandon and reset mid-grant: grant idx 3, drop req[3] → gnt_valid = 0 next cycle, no err. Then grant idx 7 and assert rst_n = 0 during BUSY → gnt_onehot = 0 next edge. After reset, req = 16'h0088 gives gnt_idx = 3 (ptr reset to 0).
